// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage in front of a 1-cycle synchronous instruction ROM
// (I_mem) that has no enable or hold control. The block owns the program
// counter, presents the ROM address, and hands decode the fetched word
// together with its PC and a valid flag.
//
// Ports
//   Clk_In         in   1      clock, all state on the rising edge
//   Reset_In       in   1      synchronous, active-high reset
//   Stall_In       in   1      hold the current instruction and PC
//   Branch_In      in   1      redirect fetch to Branch_Add_In (beats Stall_In)
//   Branch_Add_In  in   ASIZE  redirect target
//   Imem_Add_Out   out  ASIZE  ROM address (registered, = fetch PC)
//   Imem_Data_In   in   ISIZE  ROM data, word at the address latched last edge
//   Instr_Out      out  ISIZE  instruction to decode (0 when not valid)
//   PC_Out         out  ASIZE  address of Instr_Out
//   PC_Next_Out    out  ASIZE  PC_Out + 1, wraps modulo 2^ASIZE
//   Valid_Out      out  1      Instr_Out / PC_Out carry a real instruction
//
// Flow control towards decode: Valid_Out qualifies Instr_Out/PC_Out in the
// cycle they are shown. There is no ready signal; instead Stall_In sampled
// high at an edge freezes every output for the following cycle, and the
// instruction on display is delivered again until the first edge at which
// Stall_In is low. Branch_In sampled high at an edge drops Valid_Out for
// exactly one cycle and the target is shown after the next edge.
//
// Pipeline view:
//   f_pc_q  : address presented to the ROM this cycle.
//   d_pc_q  : address whose data is on Imem_Data_In this cycle.
//   d_valid_q, hold_instr_q, hold_active_q : in-flight validity and the
//   stall capture of the ROM word.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int               ISIZE    = 18,
  parameter int               ASIZE    = 10,
  parameter logic [ASIZE-1:0] RESET_PC = '0
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Stall_In,
  input  logic             Branch_In,
  input  logic [ASIZE-1:0] Branch_Add_In,
  output logic [ASIZE-1:0] Imem_Add_Out,
  input  logic [ISIZE-1:0] Imem_Data_In,
  output logic [ISIZE-1:0] Instr_Out,
  output logic [ASIZE-1:0] PC_Out,
  output logic [ASIZE-1:0] PC_Next_Out,
  output logic             Valid_Out
);

  // Per-edge action, priority already resolved (reset is handled directly
  // in the register process, so only the non-reset actions appear here).
  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } act_e;

  act_e             act;

  logic [ASIZE-1:0] f_pc_q,        f_pc_d;
  logic [ASIZE-1:0] d_pc_q,        d_pc_d;
  logic             d_valid_q,     d_valid_d;
  logic [ISIZE-1:0] hold_instr_q,  hold_instr_d;
  logic             hold_active_q, hold_active_d;

  // ---------------------------------------------------------------------
  // Action decode: redirect beats stall, stall beats advance.
  // ---------------------------------------------------------------------
  always_comb begin
    act = ACT_ADVANCE;
    if (Branch_In) begin
      act = ACT_REDIRECT;
    end else if (Stall_In) begin
      act = ACT_STALL;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    f_pc_d        = f_pc_q;
    d_pc_d        = d_pc_q;
    d_valid_d     = d_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_active_d = hold_active_q;

    case (act)
      ACT_REDIRECT: begin
        // The read launched at this edge still uses the old f_pc_q; it is
        // wrong-path, so the in-flight slot is marked invalid. d_pc_q is
        // left alone since nothing valid is being shown.
        f_pc_d        = Branch_Add_In;
        d_valid_d     = 1'b0;
        hold_active_d = 1'b0;
      end

      ACT_STALL: begin
        // The ROM keeps no output of its own: after this edge it shows
        // mem[f_pc_q] rather than the word decode is looking at, so the
        // current word is captured once, on the first stalled edge. While
        // stalled the ROM keeps re-reading f_pc_q, which is exactly the
        // word needed at the release edge.
        if (!hold_active_q) begin
          hold_instr_d  = Imem_Data_In;
          hold_active_d = 1'b1;
        end
      end

      default: begin
        d_pc_d        = f_pc_q;
        d_valid_d     = 1'b1;
        f_pc_d        = f_pc_q + ASIZE'(1);
        hold_active_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers with synchronous reset
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      f_pc_q        <= RESET_PC;
      d_pc_q        <= RESET_PC;
      d_valid_q     <= 1'b0;
      hold_instr_q  <= '0;
      hold_active_q <= 1'b0;
    end else begin
      f_pc_q        <= f_pc_d;
      d_pc_q        <= d_pc_d;
      d_valid_q     <= d_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_active_q <= hold_active_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: registers plus the ROM data only; no path from Stall_In or
  // Branch_In.
  // ---------------------------------------------------------------------
  always_comb begin
    Instr_Out = '0;
    if (d_valid_q) begin
      Instr_Out = hold_active_q ? hold_instr_q : Imem_Data_In;
    end
  end

  assign Imem_Add_Out = f_pc_q;
  assign PC_Out       = d_pc_q;
  assign PC_Next_Out  = d_pc_q + ASIZE'(1);
  assign Valid_Out    = d_valid_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the program counter, drives the address of the 1024x18 instruction ROM (`I_mem`), and presents each fetched instruction with its PC and a valid flag to decode. `I_mem` reads synchronously with one cycle of latency and has no enable or hold control. This block therefore:
- tracks the address of the read in flight;
- captures the ROM output into a hold register during stalls;
- squashes the wrong-path instruction on a branch redirect.

## Interface
Parameters:
- `ISIZE`, 18, instruction width (matches `I_mem` data width)
- `ASIZE`, 10, instruction address width (matches `I_mem` depth 1024)
- `RESET_PC`, 10'h000, first fetch address after reset

Ports:
- `Clk_In`  in  1  single clock, all state on rising edge
- `Reset_In`  in  1  synchronous, active-high reset
- `Stall_In`  in  1  hazard unit: hold current instruction and PC
- `Branch_In`  in  1  redirect fetch (taken branch/jump resolved downstream)
- `Branch_Add_In`  in  ASIZE  redirect target
- `Imem_Add_Out`  out  ASIZE  to `I_mem` `Add_In`, registered
- `Imem_Data_In`  in  ISIZE  from `I_mem` `Data_Out` (mem[address latched at previous edge])
- `Instr_Out`  out  ISIZE  instruction to decode
- `PC_Out`  out  ASIZE  address of `Instr_Out`
- `PC_Next_Out`  out  ASIZE  `PC_Out`+1, for link/relative use
- `Valid_Out`  out  1  `Instr_Out`/`PC_Out` are a real instruction

## Operation
Registers:
- `F_PC`: address presented to ROM; `Imem_Add_Out` = `F_PC`.
- `D_PC`: address of the word now on `Imem_Data_In`.
- `D_Valid`: in-flight word is valid.
- `Hold_Instr`, `Hold_Active`: stall capture.

Output equations:
- `Instr_Out` = `!D_Valid` ? 0 : (`Hold_Active` ? `Hold_Instr` : `Imem_Data_In`)
- `PC_Out` = `D_PC`
- `Valid_Out` = `D_Valid`
- `PC_Next_Out` = `D_PC`+1, mod 2^ASIZE

Per rising edge, first matching rule wins:
1. RESET (`Reset_In`=1): `F_PC`,`D_PC` <= `RESET_PC`; `D_Valid`,`Hold_Active` <= 0; `Hold_Instr` <= 0.
2. REDIRECT (`Branch_In`=1, overrides `Stall_In`): `F_PC` <= `Branch_Add_In`; `D_Valid` <= 0; `Hold_Active` <= 0. The ROM read launched at this edge (old `F_PC`) is wrong-path and discarded.
3. STALL (`Stall_In`=1):
   - `F_PC`, `D_PC`, `D_Valid` hold.
   - If `Hold_Active`=0: `Hold_Instr` <= `Imem_Data_In`, `Hold_Active` <= 1.
   - Otherwise the hold register keeps its value; no recapture.
   - The ROM re-reads `F_PC` during the stall, which is the correct refetch for the release edge.
4. ADVANCE: `D_PC` <= `F_PC`; `D_Valid` <= 1; `F_PC` <= `F_PC`+1 (wraps 0x3FF -> 0x000); `Hold_Active` <= 0.

Boundary conditions:
- Stall while `D_Valid`=0: capture still occurs; `Instr_Out` stays 0; release advances normally.
- Branch during a stall: redirect wins and the hold is cleared.
- Branch with a target equal to the current `F_PC`: same behaviour as any redirect, one bubble.
- Reset asserted mid-stall or mid-redirect: rule 1 wins and all state returns to reset values.

## Timing
- Reset values of outputs: `Imem_Add_Out`=`RESET_PC`, `Instr_Out`=0, `PC_Out`=`RESET_PC`, `PC_Next_Out`=`RESET_PC`+1, `Valid_Out`=0.
- First instruction: after the first non-reset edge, `Valid_Out`=1, `PC_Out`=`RESET_PC`, `Instr_Out`=mem[`RESET_PC`].
- Throughput: one instruction per cycle when there is no stall or branch.
- Branch penalty:
  - Branch sampled at edge k: `Valid_Out`=0 for cycle k..k+1.
  - Target instruction is valid after edge k+1. This is exactly one bubble.
- Stall:
  - Outputs are frozen from the first stalled edge through the cycle before the release edge.
  - The release edge delivers the instruction at old `F_PC`; no instruction is lost or duplicated.
- All outputs are registered or depend on registers plus `Imem_Data_In`; there are no combinational paths from `Stall_In` or `Branch_In` to outputs.

## Test plan
Bench ROM model: 1-cycle synchronous read, mem[a] = 18'h20000 | a.
- Reset then run 5 cycles -> `PC_Out` 0,1,2,3,4 with `Instr_Out` 20000..20004; `Valid_Out`=1 from the first edge; all outputs are reset values while `Reset_In`=1.
- `Stall_In` high for 3 edges while `PC_Out`=2 -> `Instr_Out` holds 20002 and `PC_Out` holds 2 throughout; after release the next values are 3/20003, with no skip or repeat.
- `Branch_In`=1, `Branch_Add_In`=0x100 while `PC_Out`=5 -> exactly one cycle of `Valid_Out`=0 and `Instr_Out`=0, then 0x100/20100, then 0x101/20101.
- `Branch_In` and `Stall_In` asserted together -> redirect taken, `Hold_Active` cleared, target 0x040 delivered after one bubble.
- Branch to 0x3FE, run 3 cycles -> `PC_Out` 3FE, 3FF, 000; `PC_Next_Out` is 000 when `PC_Out`=3FF.
- `Reset_In` asserted during a stall at `PC_Out`=7 -> next cycle `Valid_Out`=0 and `PC_Out`=`RESET_PC`; restart fetches from `RESET_PC`.
